// File: rtl/canasta_tracker.sv
// canasta_tracker: maps a received hand-position byte to a basket x target
// and slews the basket toward it by at most STEP pixels per video frame.
// Also produces the registered "paint basket" flag for the VGA pixel stream.
//
// Optional build macro: CANASTA_FILTER_EN
//   defined   -> target is the average of the last 4 mapped samples
//                (4-entry shift buffer preloaded with the centre position,
//                2-cycle target latency after rx_valid)
//   undefined -> target is the mapped sample itself (1-cycle latency)
module canasta_tracker #(
   parameter int CANASTA_W = 64,
   parameter int CANASTA_H = 16,
   parameter int Y_TOP     = 440,
   parameter int H_RES     = 640,
   parameter int STEP      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic       frame_tick,
   output logic [9:0] pos_x_target,
   output logic [9:0] pos_x_actual,
   output logic       moving,
   output logic       pintar_canasta
);

   localparam int         SPAN   = H_RES - CANASTA_W;
   localparam logic [9:0] CENTER = 10'(SPAN / 2);

   typedef enum logic {IDLE = 1'b0, MOVING = 1'b1} state_t;

   state_t      state_q;
   logic [9:0]  target_q;
   logic [9:0]  actual_q;
   logic        moving_q;
   logic        pintar_q;

   // ---------------------------------------------------------------------
   // Byte -> pixel mapping: (byte * SPAN) >> 8 at full precision
   // ---------------------------------------------------------------------
   logic [17:0] prod_w;
   logic [9:0]  sample_w;

   // scale the byte across the reachable span of the basket's left edge
   always_comb begin
      prod_w   = 18'(rx_byte) * 18'(SPAN);
      sample_w = 10'(prod_w >> 8);
   end

`ifdef CANASTA_FILTER_EN
   // ---------------------------------------------------------------------
   // Moving-average filter over the last four samples
   // ---------------------------------------------------------------------
   logic [3:0][9:0] hist_q;
   logic            fil_vld_q;
   logic [11:0]     hist_sum_w;

   // sum of the four buffered samples, wide enough for 4 x 10-bit values
   always_comb begin
      hist_sum_w = 12'(hist_q[0]) + 12'(hist_q[1]) + 12'(hist_q[2]) + 12'(hist_q[3]);
   end

   // shift new samples in; the average lands in the target one cycle later
   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q    <= {4{CENTER}};
         fil_vld_q <= 1'b0;
         target_q  <= CENTER;
      end else begin
         fil_vld_q <= rx_valid;
         if (rx_valid) hist_q <= {hist_q[2:0], sample_w};
         if (fil_vld_q) target_q <= 10'(hist_sum_w >> 2);
      end
   end
`else
   // target follows the mapped sample directly, one cycle after rx_valid
   always_ff @(posedge clk) begin
      if (reset) begin
         target_q <= CENTER;
      end else if (rx_valid) begin
         target_q <= sample_w;
      end
   end
`endif

   // ---------------------------------------------------------------------
   // Slew computation (11-bit, unsigned distance, no wrap)
   // ---------------------------------------------------------------------
   logic        go_right_w;
   logic [10:0] dist_w;
   logic        close_w;
   logic [9:0]  stepped_w;

   // distance to target and the position one STEP closer to it
   always_comb begin
      go_right_w = (target_q > actual_q);
      if (go_right_w) dist_w = {1'b0, target_q} - {1'b0, actual_q};
      else            dist_w = {1'b0, actual_q} - {1'b0, target_q};
      close_w = (dist_w <= 11'(STEP));
      // only used when dist > STEP, so neither direction can wrap
      if (go_right_w) stepped_w = actual_q + 10'(STEP);
      else            stepped_w = actual_q - 10'(STEP);
   end

   // two-state motion FSM; position only changes on frame_tick so the
   // basket never tears mid-frame. The step always uses the target held
   // before this edge, so a same-cycle rx_valid applies from the next tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         actual_q <= CENTER;
         moving_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (target_q != actual_q) begin
                  state_q  <= MOVING;
                  moving_q <= 1'b1;
               end
            end
            MOVING: begin
               if (frame_tick) begin
                  if (close_w) begin
                     actual_q <= target_q;
                     state_q  <= IDLE;
                     moving_q <= 1'b0;
                  end else begin
                     actual_q <= stepped_w;
                  end
               end
            end
            default: begin
               state_q  <= IDLE;
               moving_q <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Pixel hit test (11-bit so the right edge cannot overflow)
   // ---------------------------------------------------------------------
   logic [10:0] px_w, py_w, x_lo_w, x_hi_w;
   logic        hit_w;

   // basket rectangle membership for the current pixel
   always_comb begin
      px_w   = {1'b0, pixel_x};
      py_w   = {1'b0, pixel_y};
      x_lo_w = {1'b0, actual_q};
      x_hi_w = {1'b0, actual_q} + 11'(CANASTA_W - 1);
      hit_w  = (px_w >= x_lo_w) && (px_w <= x_hi_w) &&
               (py_w >= 11'(Y_TOP)) && (py_w <= 11'(Y_TOP + CANASTA_H - 1));
   end

   // register the hit flag for a clean one-cycle-latency paint output
   always_ff @(posedge clk) begin
      if (reset) pintar_q <= 1'b0;
      else       pintar_q <= hit_w;
   end

   assign pos_x_target   = target_q;
   assign pos_x_actual   = actual_q;
   assign moving         = moving_q;
   assign pintar_canasta = pintar_q;

endmodule

// File: tb/tb_canasta_tracker.sv
// Testbench for canasta_tracker: directed scenarios plus randomized traffic.
// A reference model (plain integer arithmetic) predicts every cycle's
// outputs into a queue; an independent monitor pops and compares.
module tb_canasta_tracker;

   localparam int W    = 64;
   localparam int H    = 16;
   localparam int YT   = 440;
   localparam int HRES = 640;
   localparam int STEP = 4;
   localparam int SPAN = HRES - W;
   localparam int CTR  = SPAN / 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_byte = 8'd0;
   logic       rx_valid = 1'b0;
   logic [9:0] pixel_x = 10'd0;
   logic [9:0] pixel_y = 10'd0;
   logic       frame_tick = 1'b0;
   logic [9:0] pos_x_target, pos_x_actual;
   logic       moving, pintar_canasta;

   canasta_tracker #(.CANASTA_W(W), .CANASTA_H(H), .Y_TOP(YT), .H_RES(HRES), .STEP(STEP)) dut (
      .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_tick(frame_tick),
      .pos_x_target(pos_x_target), .pos_x_actual(pos_x_actual),
      .moving(moving), .pintar_canasta(pintar_canasta));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int tgt;
      int act;
      int mv;
      int pin;
   } exp_t;
   exp_t sb[$];

   // ---------------- reference model ----------------
   int m_tgt = CTR, m_act = CTR, m_mv = 0;
   int m_hist[$] = '{CTR, CTR, CTR, CTR};
   int m_pend = 0, m_pend_val = 0;

   always @(posedge clk) begin
      int nt, na, nm, np, d, s;
      exp_t e;
      if (reset) begin
         m_tgt = CTR; m_act = CTR; m_mv = 0; np = 0;
         m_hist = '{CTR, CTR, CTR, CTR}; m_pend = 0;
      end else begin
         nt = m_tgt; na = m_act; nm = m_mv;
         np = (int'(pixel_x) >= m_act && int'(pixel_x) <= m_act + W - 1 &&
               int'(pixel_y) >= YT && int'(pixel_y) <= YT + H - 1) ? 1 : 0;
         if (m_mv != 0) begin
            if (frame_tick) begin
               d = m_tgt - m_act;
               if (d <= STEP && d >= -STEP) begin na = m_tgt; nm = 0; end
               else na = m_act + ((d > 0) ? STEP : -STEP);
            end
         end else if (m_tgt != m_act) begin
            nm = 1;
         end
         s = (int'(rx_byte) * SPAN) / 256;
`ifdef CANASTA_FILTER_EN
         if (m_pend != 0) nt = m_pend_val;
         m_pend = 0;
         if (rx_valid) begin
            m_hist.push_back(s);
            void'(m_hist.pop_front());
            m_pend = 1;
            m_pend_val = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
         end
`else
         if (rx_valid) nt = s;
`endif
         m_tgt = nt; m_act = na; m_mv = nm;
      end
      e.tgt = m_tgt; e.act = m_act; e.mv = m_mv; e.pin = np;
      sb.push_back(e);
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         n_tests++;
         if (int'(pos_x_target) != e.tgt || int'(pos_x_actual) != e.act ||
             int'(moving) != e.mv || int'(pintar_canasta) != e.pin) begin
            n_fail++;
            $display("FAIL scoreboard t=%0t: got tgt=%0d act=%0d mv=%0d pin=%0d, expected tgt=%0d act=%0d mv=%0d pin=%0d",
                     $time, pos_x_target, pos_x_actual, moving, pintar_canasta, e.tgt, e.act, e.mv, e.pin);
         end
         if (int'(pos_x_actual) > SPAN) begin
            n_tests++; n_fail++;
            $display("FAIL range: pos_x_actual=%0d exceeds %0d", pos_x_actual, SPAN);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_byte = b; rx_valid = 1'b1; cyc(); rx_valid = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin frame_tick = 1'b1; cyc(); frame_tick = 1'b0; end
   endtask

   task automatic do_reset();
      reset = 1'b1; cyc(); reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      pixel_y = 10'd0;
      cyc(2);
      reset = 1'b0;
      chk("reset_target", pos_x_target, 288);
      chk("reset_actual", pos_x_actual, 288);
      chk("reset_moving", moving, 0);
      chk("reset_pintar", pintar_canasta, 0);

`ifndef CANASTA_FILTER_EN
      // full-right move: 288 -> 573 in 72 ticks
      send(8'd255);
      chk("target_255", pos_x_target, 573);
      chk("no_move_without_tick", pos_x_actual, 288);
      cyc();
      chk("moving_rises", moving, 1);
      ticks(1); chk("tick1_actual", pos_x_actual, 292);
      ticks(1); chk("tick2_actual", pos_x_actual, 296);
      ticks(69); chk("tick71_actual", pos_x_actual, 572);
      chk("tick71_moving", moving, 1);
      ticks(1); chk("tick72_actual", pos_x_actual, 573);
      chk("tick72_moving", moving, 0);

      // reset aborts motion mid-way
      send(8'd0); cyc();
      ticks(10); chk("abort_pre_actual", pos_x_actual, 533);
      do_reset();
      chk("abort_actual", pos_x_actual, 288);
      chk("abort_target", pos_x_target, 288);
      chk("abort_moving", moving, 0);

      // full-left move: 288 -> 0, no underflow
      send(8'd0); cyc();
      ticks(71); chk("left71_actual", pos_x_actual, 4);
      ticks(1); chk("left72_actual", pos_x_actual, 0);
      chk("left72_moving", moving, 0);
      ticks(3); chk("left_hold_zero", pos_x_actual, 0);

      // rx_valid and frame_tick together: step uses the old target
      do_reset();
      rx_byte = 8'd255; rx_valid = 1'b1; frame_tick = 1'b1; cyc();
      rx_valid = 1'b0; frame_tick = 1'b0;
      chk("same_cycle_target", pos_x_target, 573);
      chk("same_cycle_actual", pos_x_actual, 288);
      cyc();
      ticks(1); chk("same_cycle_next_tick", pos_x_actual, 292);

      // park actual at 300 (target 301, no further ticks) and sweep pixels
      do_reset();
      send(8'd134); cyc();
      ticks(3); chk("park_actual", pos_x_actual, 300);
      pixel_y = 10'd445;
      pixel_x = 10'd300; cyc(); chk("pix_300", pintar_canasta, 1);
      pixel_x = 10'd363; cyc(); chk("pix_363", pintar_canasta, 1);
      pixel_x = 10'd299; cyc(); chk("pix_299", pintar_canasta, 0);
      pixel_x = 10'd364; cyc(); chk("pix_364", pintar_canasta, 0);
      pixel_x = 10'd330; pixel_y = 10'd439; cyc(); chk("pix_y439", pintar_canasta, 0);
      pixel_y = 10'd456; cyc(); chk("pix_y456", pintar_canasta, 0);
      pixel_y = 10'd455; cyc(); chk("pix_y455", pintar_canasta, 1);
      pixel_y = 10'd0;
`else
      // averaged targets for four full-scale bytes
      rx_byte = 8'd255; rx_valid = 1'b1; cyc(); rx_valid = 1'b0;
      chk("filt_latency", pos_x_target, 288);
      cyc(); chk("filt_t1", pos_x_target, 359);
      send(8'd255); cyc(); chk("filt_t2", pos_x_target, 430);
      send(8'd255); cyc(); chk("filt_t3", pos_x_target, 501);
      send(8'd255); cyc(); chk("filt_t4", pos_x_target, 573);
`endif

      // randomized traffic, judged by the scoreboard
      for (int i = 0; i < 4000; i++) begin
         int base;
         reset      = ($urandom_range(0, 199) == 0);
         rx_valid   = ($urandom_range(0, 19) == 0);
         rx_byte    = 8'($urandom_range(0, 255));
         frame_tick = ($urandom_range(0, 3) == 0);
         base       = m_act + $urandom_range(0, 140) - 70;
         if (base < 0) base = 0;
         if ($urandom_range(0, 9) == 0) base = $urandom_range(560, 1023);
         pixel_x    = 10'(base);
         pixel_y    = 10'($urandom_range(YT - 3, YT + H + 2));
         cyc();
      end
      reset = 1'b0; rx_valid = 1'b0; frame_tick = 1'b0;
      cyc(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/canasta_tracker.md
CANASTA_TRACKER -- requirements
Module: canasta_tracker

Interface
REQ-001 Parameter CANASTA_W, default 64: basket width in pixels.
REQ-002 Parameter CANASTA_H, default 16: basket height in pixels.
REQ-003 Parameter Y_TOP, default 440: top row of the basket.
REQ-004 Parameter H_RES, default 640: visible horizontal resolution.
REQ-005 Parameter STEP, default 4: maximum pixels moved per frame, range 1..63.
REQ-006 The module SHALL have one clock and a synchronous, active-high reset: port clk (input, 1, system clock) and port reset (input, 1, synchronous active-high reset), listed first.
REQ-007 Port rx_byte, input, 8: received hand-position byte.
REQ-008 Port rx_valid, input, 1: one-cycle strobe meaning rx_byte is valid.
REQ-009 Port pixel_x, input, 10: current VGA column.
REQ-010 Port pixel_y, input, 10: current VGA row.
REQ-011 Port frame_tick, input, 1: one-cycle pulse, once per frame at the start of vertical blank.
REQ-012 Port pos_x_target, output, 10: mapped target x position.
REQ-013 Port pos_x_actual, output, 10: current basket left edge.
REQ-014 Port moving, output, 1: high while pos_x_actual differs from pos_x_target.
REQ-015 Port pintar_canasta, output, 1: pixel lies inside the basket.

Function
REQ-016 Mapping: on rx_valid, sample = (rx_byte * (H_RES-CANASTA_W)) >> 8, computed at full precision and truncated to 10 bits; range is 0..H_RES-CANASTA_W-1.
REQ-017 pos_x_target SHALL update on the clock edge after rx_valid (1-cycle latency); rx_valid without frame_tick never moves pos_x_actual.
REQ-018 The FSM SHALL have exactly two states: IDLE (pos_x_actual == pos_x_target) and MOVING (pos_x_actual != pos_x_target).
REQ-019 Position update in MOVING occurs only on a frame_tick cycle, so the basket never tears mid-frame.
- |target-actual| <= STEP: actual = target, then go to IDLE.
- Otherwise actual moves STEP toward target, and the state stays MOVING.
REQ-020 In IDLE, when a new target differs from actual, the FSM SHALL enter MOVING on the next cycle; moving = (state == MOVING), registered.
REQ-021 When rx_valid and frame_tick occur in the same cycle, the frame step SHALL use the old target; the new target applies from the next frame_tick.
REQ-022 A new target that arrives mid-motion SHALL redirect motion at the next frame_tick without overshoot; direction may reverse.
REQ-023 pos_x_actual SHALL never leave 0..H_RES-CANASTA_W, with no underflow or wrap.
REQ-024 pintar_canasta SHALL be registered (1-cycle latency) and high iff pos_x_actual <= pixel_x <= pos_x_actual+CANASTA_W-1 and Y_TOP <= pixel_y <= Y_TOP+CANASTA_H-1.
REQ-025 The range compare SHALL use 11-bit arithmetic, so there is no overflow at the right edge.

Reset
REQ-026 On reset, pos_x_actual and pos_x_target SHALL be (H_RES-CANASTA_W)/2 (288 at defaults), the state IDLE, moving 0, and pintar_canasta 0.
REQ-027 Reset asserted mid-motion SHALL abort the motion within one cycle; rx_valid and frame_tick are ignored while reset is high.

Configuration
REQ-028 Macro CANASTA_FILTER_EN defined: target = sum of the last 4 mapped samples >> 2, stored in a 4-entry shift buffer.
- The buffer is preloaded with the reset centre value.
- Target latency after rx_valid is 2 cycles.
REQ-029 Macro CANASTA_FILTER_EN undefined: target = mapped sample directly, per REQ-017; no buffer is instantiated.

Verification
REQ-030 Reset, then rx_byte=255 with rx_valid -> pos_x_target=573 next cycle; pos_x_actual reads 292, 296, ... per frame_tick; reaches 573 on the 72nd tick; moving falls the cycle after.
REQ-031 From 288, rx_byte=0 -> target 0; after 72 frame_ticks actual=0, never negative and never wrapped.
REQ-032 rx_valid and frame_tick in the same cycle, target 288 -> 573 -> first step uses 288 (no motion); motion starts on the next tick.
REQ-033 actual=300, pixel_y=445 -> pintar_canasta high one cycle after pixel_x=300..363; low at 299 and 364; low for pixel_y=439 and 456.
REQ-034 Reset pulsed after 10 ticks of motion -> actual=288, target=288, moving=0 one cycle later.
REQ-035 With CANASTA_FILTER_EN, four bytes of 255 from reset -> targets 359, 430, 501, 573.
